// File: rtl/tryx_pkg.sv
// Shared constants, types and the address predicate for the TRYX controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tryx_pkg;

    // Register window offsets relative to the CTRL word address
    localparam logic [31:0] REG_OFF_CTRL     = 32'd0;
    localparam logic [31:0] REG_OFF_STATUS   = 32'd4;
    localparam logic [31:0] REG_OFF_ERR_ADDR = 32'd8;

    // STATUS field positions
    localparam int unsigned STAT_SLVERR_BIT = 0;
    localparam int unsigned STAT_ERRCNT_LSB = 8;
    localparam int unsigned STAT_ERRCNT_MSB = 15;
    localparam int unsigned STAT_OUTST_LSB  = 16;
    localparam int unsigned STAT_OUTST_MSB  = 23;

    localparam logic [7:0] ERRCNT_MAX = 8'hFF;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_STICKY  = 1'b1
    } mode_e;

    // An address leaves the cluster when it does not fall inside the local window
    function automatic logic is_external(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] mask);
        return (addr & mask) != base;
    endfunction

endpackage

// File: rtl/xbar_periph_bus.sv
// Peripheral interconnect request/response bundle between core and crossbar.
// Latency: n/a (wiring only).
// Backpressure: req held until gnt; one r_valid pulse per granted request.
interface XBAR_PERIPH_BUS;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic        r_valid;

    modport Master (output req, add, wen, wdata, be,
                    input  gnt, r_opc, r_rdata, r_valid);
    modport Slave  (input  req, add, wen, wdata, be,
                    output gnt, r_opc, r_rdata, r_valid);
endinterface

// File: rtl/tryx_addr_fifo.sv
// In-order tracker of external request addresses, one entry per transaction in flight.
// Latency: push visible at head one cycle later; head is combinational from storage.
// Backpressure: push accepted when not full or when a valid pop happens the same cycle.
module tryx_addr_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [31:0]   din_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   usage_o,
    output logic [31:0]   head_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pop_ok, push_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != FULL_CNT) || pop_ok);

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // Pointer/occupancy update; head is read from the old storage before the write lands
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din_i;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tryx_ctrl_mo.sv
// Per-core TRYX controller: AxUSER tagging, outstanding-address tracking, error capture window.
// Latency: pass-through combinational; register window answers one cycle after req.
// Backpressure: external req/gnt held off while the core's tracker is full and no response pops.
module tryx_ctrl_mo
    import tryx_pkg::*;
#(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] REG_BASE_ADDR   = 32'h1020_0BF4,
    parameter logic [31:0] CL_BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] CL_ADDR_MASK    = 32'hFFC0_0000
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    output logic [NB_CORES-1:0][AXI_USER_WIDTH-1:0]       axi_axuser_o,
    input  logic [NB_CORES-1:0]                           axi_xresp_slverr_i,
    input  logic [NB_CORES-1:0]                           axi_xresp_valid_i,
    XBAR_PERIPH_BUS.Slave                                 periph_data_slave  [NB_CORES],
    XBAR_PERIPH_BUS.Master                                periph_data_master [NB_CORES]
);
    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        logic                      s_req, s_wen, m_req, m_gnt;
        logic [31:0]               s_add, s_wdata, off, head, status, ctrl;
        logic                      reg_hit, reg_acc, reg_wr, clr, ext, fwd_ok;
        logic                      push, pop, full, empty;
        logic [AW:0]               usage;
        logic [AXI_USER_WIDTH-1:0] user_q, user_d;
        mode_e                     mode_q, mode_d;
        logic                      slverr_q, slverr_d;
        logic [7:0]                errcnt_q, errcnt_d;
        logic [31:0]               err_addr_q, err_addr_d;
        logic                      rsp_vld_q, rsp_vld_d;
        logic [31:0]               rsp_dat_q, rsp_dat_d;

        assign s_req   = periph_data_slave[i].req;
        assign s_add   = periph_data_slave[i].add;
        assign s_wen   = periph_data_slave[i].wen;
        assign s_wdata = periph_data_slave[i].wdata;
        assign m_gnt   = periph_data_master[i].gnt;

        // Register window decode; offsets wrap so only the three exact words hit
        assign off     = s_add - REG_BASE_ADDR;
        assign reg_hit = (off == REG_OFF_CTRL) || (off == REG_OFF_STATUS) ||
                         (off == REG_OFF_ERR_ADDR);
        assign reg_acc = s_req && reg_hit;
        assign reg_wr  = reg_acc && !s_wen;
        assign clr     = reg_acc && s_wen && (off == REG_OFF_STATUS);

        // External requests stall only when the tracker is full and nothing retires
        assign ext     = is_external(s_add, CL_BASE_ADDR, CL_ADDR_MASK) && !reg_hit;
        assign pop     = axi_xresp_valid_i[i];
        assign fwd_ok  = !ext || !full || pop;
        assign m_req   = s_req && !reg_hit && fwd_ok;
        assign push    = ext && m_req && m_gnt;

        assign periph_data_master[i].req   = m_req;
        assign periph_data_master[i].add   = s_add;
        assign periph_data_master[i].wen   = reg_hit ? 1'b1 : s_wen;
        assign periph_data_master[i].wdata = s_wdata;
        assign periph_data_master[i].be    = periph_data_slave[i].be;
        assign periph_data_slave[i].gnt    = reg_hit ? 1'b1 : (fwd_ok && m_gnt);

        // A pending register response owns the return path for its cycle
        assign periph_data_slave[i].r_valid = rsp_vld_q ? 1'b1 : periph_data_master[i].r_valid;
        assign periph_data_slave[i].r_opc   = rsp_vld_q ? 1'b0 : periph_data_master[i].r_opc;
        assign periph_data_slave[i].r_rdata = rsp_vld_q ? rsp_dat_q : periph_data_master[i].r_rdata;

        assign axi_axuser_o[i] = (s_req && ext) ? user_q : '0;

        tryx_addr_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push),
            .din_i   (s_add),
            .pop_i   (pop),
            .full_o  (full),
            .empty_o (empty),
            .usage_o (usage),
            .head_o  (head)
        );

        // Read views of CTRL and STATUS
        always_comb begin
            ctrl = '0;
            ctrl[31 -: AXI_USER_WIDTH] = user_q;
            ctrl[0] = mode_q;
            status = '0;
            status[STAT_SLVERR_BIT] = slverr_q;
            status[STAT_ERRCNT_MSB:STAT_ERRCNT_LSB] = errcnt_q;
            status[STAT_OUTST_MSB:STAT_OUTST_LSB] = 8'(usage);
        end

        // Next-state: CTRL write beats one-shot consumption; a new error beats clear-on-read
        always_comb begin
            user_d     = user_q;
            mode_d     = mode_q;
            slverr_d   = slverr_q;
            errcnt_d   = errcnt_q;
            err_addr_d = err_addr_q;
            rsp_vld_d  = reg_acc;
            rsp_dat_d  = '0;
            if (reg_wr && (off == REG_OFF_CTRL)) begin
                user_d = s_wdata[31 -: AXI_USER_WIDTH];
                mode_d = mode_e'(s_wdata[0]);
            end else if (push && (mode_q == MODE_ONESHOT)) begin
                user_d = '0;
            end
            if (clr) begin
                slverr_d = 1'b0;
                errcnt_d = '0;
            end
            if (pop && axi_xresp_slverr_i[i]) begin
                slverr_d = 1'b1;
                if (errcnt_d != ERRCNT_MAX) begin
                    errcnt_d = errcnt_d + 8'd1;
                end
                if (!empty) begin
                    err_addr_d = head;
                end
            end
            if (reg_acc && s_wen) begin
                case (off)
                    REG_OFF_CTRL:     rsp_dat_d = ctrl;
                    REG_OFF_STATUS:   rsp_dat_d = status;
                    REG_OFF_ERR_ADDR: rsp_dat_d = err_addr_q;
                    default:          rsp_dat_d = '0;
                endcase
            end
        end

        // Control/status registers with synchronous clear
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                user_q     <= '0;
                mode_q     <= MODE_ONESHOT;
                slverr_q   <= 1'b0;
                errcnt_q   <= '0;
                err_addr_q <= '0;
                rsp_vld_q  <= 1'b0;
                rsp_dat_q  <= '0;
            end else begin
                user_q     <= user_d;
                mode_q     <= mode_d;
                slverr_q   <= slverr_d;
                errcnt_q   <= errcnt_d;
                err_addr_q <= err_addr_d;
                rsp_vld_q  <= rsp_vld_d;
                rsp_dat_q  <= rsp_dat_d;
            end
        end
    end

endmodule

// File: tb/tb_tryx_ctrl_mo.sv
// Self-checking bench for tryx_ctrl_mo: register window, tagging, tracker back-pressure, errors.
// Latency: register reads answered one cycle after request, tracked by a response scoreboard.
// Backpressure: bench plays the interconnect, holding gnt high unless a scenario drops it.
module tb_tryx_ctrl_mo;
    localparam int NB = 4;
    localparam int UW = 6;
    localparam logic [31:0] CTRL_A = 32'h1020_0BF4;
    localparam logic [31:0] STAT_A = 32'h1020_0BF8;
    localparam logic [31:0] ERRA_A = 32'h1020_0BFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        s_req [NB], s_wen [NB], s_gnt [NB], s_rvalid [NB], s_ropc [NB];
    logic [31:0] s_add [NB], s_wdata [NB], s_rdata [NB];
    logic        m_req [NB], m_wen [NB], m_gnt [NB], m_rvalid [NB], m_ropc [NB];
    logic [31:0] m_add [NB], m_rdata [NB];
    logic [NB-1:0][UW-1:0] axuser;
    logic [NB-1:0] slverr, xvalid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          core;
        logic        chk;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    XBAR_PERIPH_BUS slv [NB] ();
    XBAR_PERIPH_BUS mst [NB] ();

    for (genvar g = 0; g < NB; g++) begin : g_bus
        assign slv[g].req   = s_req[g];
        assign slv[g].add   = s_add[g];
        assign slv[g].wen   = s_wen[g];
        assign slv[g].wdata = s_wdata[g];
        assign slv[g].be    = 4'hF;
        assign s_gnt[g]     = slv[g].gnt;
        assign s_rvalid[g]  = slv[g].r_valid;
        assign s_ropc[g]    = slv[g].r_opc;
        assign s_rdata[g]   = slv[g].r_rdata;
        assign m_req[g]     = mst[g].req;
        assign m_add[g]     = mst[g].add;
        assign m_wen[g]     = mst[g].wen;
        assign mst[g].gnt     = m_gnt[g];
        assign mst[g].r_valid = m_rvalid[g];
        assign mst[g].r_opc   = m_ropc[g];
        assign mst[g].r_rdata = m_rdata[g];
    end

    tryx_ctrl_mo #(
        .NB_CORES(NB), .AXI_USER_WIDTH(UW), .MAX_OUTSTANDING(4),
        .REG_BASE_ADDR(32'h1020_0BF4), .CL_BASE_ADDR(32'h1000_0000), .CL_ADDR_MASK(32'hFFC0_0000)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .axi_axuser_o       (axuser),
        .axi_xresp_slverr_i (slverr),
        .axi_xresp_valid_i  (xvalid),
        .periph_data_slave  (slv),
        .periph_data_master (mst)
    );

    // Scoreboard: every register-window response is popped and compared in order
    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (s_rvalid[c] === 1'b1 && m_rvalid[c] !== 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: core %0d r_valid with no expected response", c);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.core != c || s_ropc[c] !== 1'b0 || (e.chk && s_rdata[c] !== e.data)) begin
                        errors++;
                        $display("FAIL sb_rdata: core %0d rdata %h opc %b, expected core %0d rdata %h opc 0",
                                 c, s_rdata[c], s_ropc[c], e.core, e.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_op(input int c, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [31:0] exp);
        s_req[c] = 1'b1; s_add[c] = a; s_wen[c] = ~we; s_wdata[c] = wd;
        sb_q.push_back('{core: c, chk: ~we, data: exp});
        tick();
        s_req[c] = 1'b0; s_wen[c] = 1'b1;
        tick();
    endtask

    task automatic ext_req(input int c, input logic [31:0] a, input logic rd);
        s_req[c] = 1'b1; s_add[c] = a; s_wen[c] = rd; s_wdata[c] = a;
    endtask

    task automatic resp(input int c, input logic err, input int n);
        xvalid[c] = 1'b1; slverr[c] = err;
        repeat (n) tick();
        xvalid[c] = 1'b0; slverr[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        if (axuser !== '0) begin errors++; $display("FAIL reset_axuser: got %h expected 0", axuser); end
        checks++;
        m_rvalid[0] = 1'b1; m_ropc[0] = 1'b1; m_rdata[0] = 32'h1234_5678;
        #1;
        if (s_rvalid[0] !== 1'b1 || s_ropc[0] !== 1'b1 || s_rdata[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_rpass: got v=%b opc=%b d=%h expected v=1 opc=1 d=12345678",
                     s_rvalid[0], s_ropc[0], s_rdata[0]);
        end
        checks++;
        tick();
        m_rvalid[0] = 1'b0; m_ropc[0] = 1'b0; m_rdata[0] = '0;
        reg_op(0, CTRL_A, 1'b0, 0, 32'h0);
        reg_op(0, STAT_A, 1'b0, 0, 32'h0);
        reg_op(0, ERRA_A, 1'b0, 0, 32'h0);
    endtask

    task automatic test_oneshot();
        s_req[0] = 1'b1; s_add[0] = CTRL_A; s_wen[0] = 1'b0; s_wdata[0] = 32'hFC00_0000;
        sb_q.push_back('{core: 0, chk: 1'b0, data: 32'h0});
        @(negedge clk);
        if (m_req[0] !== 1'b0 || m_wen[0] !== 1'b1 || s_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL reg_nofwd: got mreq=%b mwen=%b gnt=%b expected 0 1 1", m_req[0], m_wen[0], s_gnt[0]);
        end
        checks++;
        tick();
        ext_req(0, 32'h2000_0000, 1'b1);
        @(negedge clk);
        if (s_gnt[0] !== 1'b1 || m_req[0] !== 1'b1 || axuser[0] !== 6'h3F) begin
            errors++;
            $display("FAIL oneshot_first: got gnt=%b mreq=%b axuser=%h expected 1 1 3f", s_gnt[0], m_req[0], axuser[0]);
        end
        checks++;
        tick();
        @(negedge clk);
        if (axuser[0] !== 6'h00) begin errors++; $display("FAIL oneshot_second: got %h expected 00", axuser[0]); end
        checks++;
        tick();
        s_req[0] = 1'b0;
        reg_op(0, CTRL_A, 1'b0, 0, 32'h0);
        resp(0, 1'b0, 2);
    endtask

    task automatic test_backpressure();
        reg_op(0, CTRL_A, 1'b1, 32'hFC00_0001, 0);
        for (int k = 0; k < 4; k++) begin
            ext_req(0, 32'h2000_0000 + 32'(k * 4), 1'b0);
            @(negedge clk);
            if (s_gnt[0] !== 1'b1 || axuser[0] !== 6'h3F) begin
                errors++;
                $display("FAIL bp_grant%0d: got gnt=%b axuser=%h expected 1 3f", k, s_gnt[0], axuser[0]);
            end
            checks++;
            tick();
        end
        ext_req(0, 32'h2000_0010, 1'b0);
        @(negedge clk);
        if (s_gnt[0] !== 1'b0 || m_req[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got gnt=%b mreq=%b expected 0 0", s_gnt[0], m_req[0]);
        end
        checks++;
        tick();
        xvalid[0] = 1'b1;
        @(negedge clk);
        if (s_gnt[0] !== 1'b1 || m_req[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got gnt=%b mreq=%b expected 1 1", s_gnt[0], m_req[0]);
        end
        checks++;
        tick();
        xvalid[0] = 1'b0; s_req[0] = 1'b0;
        reg_op(0, STAT_A, 1'b0, 0, 32'h0004_0000);
        resp(0, 1'b0, 4);
    endtask

    task automatic test_err_addr();
        for (int k = 0; k < 3; k++) begin
            ext_req(0, 32'h2000_0000 + 32'(k * 16), 1'b1);
            tick();
        end
        s_req[0] = 1'b0;
        resp(0, 1'b0, 1);
        resp(0, 1'b1, 1);
        resp(0, 1'b0, 1);
        reg_op(0, ERRA_A, 1'b0, 0, 32'h2000_0010);
        reg_op(0, STAT_A, 1'b0, 0, 32'h0000_0101);
        reg_op(0, STAT_A, 1'b0, 0, 32'h0000_0000);
    endtask

    task automatic test_clear_race();
        ext_req(0, 32'h2000_0200, 1'b1);
        tick();
        s_req[0] = 1'b0;
        resp(0, 1'b1, 1);
        ext_req(0, 32'h3000_0000, 1'b1);
        tick();
        s_req[0] = 1'b0;
        xvalid[0] = 1'b1; slverr[0] = 1'b1;
        s_req[0] = 1'b1; s_add[0] = STAT_A; s_wen[0] = 1'b1;
        sb_q.push_back('{core: 0, chk: 1'b1, data: 32'h0001_0101});
        tick();
        s_req[0] = 1'b0; xvalid[0] = 1'b0; slverr[0] = 1'b0;
        tick();
        reg_op(0, STAT_A, 1'b0, 0, 32'h0000_0101);
        reg_op(0, ERRA_A, 1'b0, 0, 32'h3000_0000);
        ext_req(0, 32'h2000_0100, 1'b1);
        tick();
        xvalid[0] = 1'b1; slverr[0] = 1'b1;
        repeat (299) tick();
        s_req[0] = 1'b0;
        tick();
        xvalid[0] = 1'b0; slverr[0] = 1'b0;
        reg_op(0, STAT_A, 1'b0, 0, 32'h0000_FF01);
        reg_op(0, ERRA_A, 1'b0, 0, 32'h2000_0100);
    endtask

    task automatic test_reset_outstanding();
        reg_op(1, CTRL_A, 1'b1, 32'h0400_0000, 0);
        for (int k = 0; k < 3; k++) begin
            ext_req(0, 32'h4000_0000 + 32'(k * 4), 1'b0);
            ext_req(1, 32'h5000_0000 + 32'(k * 4), 1'b0);
            @(negedge clk);
            if (k == 0 && (axuser[0] !== 6'h3F || axuser[1] !== 6'h01)) begin
                errors++;
                $display("FAIL dual_tag_first: got %h/%h expected 3f/01", axuser[0], axuser[1]);
            end
            if (k == 1 && (axuser[0] !== 6'h3F || axuser[1] !== 6'h00)) begin
                errors++;
                $display("FAIL dual_tag_second: got %h/%h expected 3f/00", axuser[0], axuser[1]);
            end
            if (k < 2) checks++;
            tick();
        end
        s_req[0] = 1'b0; s_req[1] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        xvalid[0] = 1'b1; xvalid[1] = 1'b1;
        repeat (3) tick();
        xvalid[0] = 1'b0; xvalid[1] = 1'b0;
        reg_op(0, CTRL_A, 1'b0, 0, 32'h0);
        reg_op(0, STAT_A, 1'b0, 0, 32'h0);
        reg_op(0, ERRA_A, 1'b0, 0, 32'h0);
        reg_op(1, STAT_A, 1'b0, 0, 32'h0);
        reg_op(1, ERRA_A, 1'b0, 0, 32'h0);
    endtask

    task automatic test_local_full();
        for (int k = 0; k < 4; k++) begin
            ext_req(2, 32'h2000_0000 + 32'(k * 4), 1'b1);
            tick();
        end
        s_req[2] = 1'b0;
        reg_op(2, CTRL_A, 1'b1, 32'h0800_0000, 0);
        m_gnt[2] = 1'b0;
        ext_req(2, 32'h1000_0040, 1'b1);
        @(negedge clk);
        if (m_req[2] !== 1'b1 || s_gnt[2] !== 1'b0 || m_add[2] !== 32'h1000_0040 || axuser[2] !== 6'h00) begin
            errors++;
            $display("FAIL local_fwd: got mreq=%b gnt=%b add=%h axuser=%h expected 1 0 10000040 00",
                     m_req[2], s_gnt[2], m_add[2], axuser[2]);
        end
        checks++;
        tick();
        m_gnt[2] = 1'b1;
        @(negedge clk);
        if (s_gnt[2] !== 1'b1) begin errors++; $display("FAIL local_gnt: got %b expected 1", s_gnt[2]); end
        checks++;
        tick();
        ext_req(2, 32'h2000_0040, 1'b1);
        @(negedge clk);
        if (s_gnt[2] !== 1'b0 || axuser[2] !== 6'h02) begin
            errors++;
            $display("FAIL full_ext_stall: got gnt=%b axuser=%h expected 0 02", s_gnt[2], axuser[2]);
        end
        checks++;
        tick();
        s_req[2] = 1'b0;
        reg_op(2, CTRL_A, 1'b0, 0, 32'h0800_0000);
        reg_op(2, STAT_A, 1'b0, 0, 32'h0004_0000);
        resp(2, 1'b0, 4);
    endtask

    initial begin
        rst = 1'b1;
        for (int c = 0; c < NB; c++) begin
            s_req[c] = 1'b0; s_wen[c] = 1'b1; s_add[c] = '0; s_wdata[c] = '0;
            m_gnt[c] = 1'b1; m_rvalid[c] = 1'b0; m_ropc[c] = 1'b0; m_rdata[c] = '0;
        end
        slverr = '0;
        xvalid = '0;
        test_reset();
        test_oneshot();
        test_backpressure();
        test_err_addr();
        test_clear_race();
        test_reset_outstanding();
        test_local_full();
        repeat (3) tick();
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses still expected, required 0", sb_q.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
